// File: rtl/mem_stage.sv
// Memory-access stage: pass-through of ALU results, data-memory handshake with
// byte-lane steering, load extension, misalignment/funct3 checks and a wait timeout.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_flush,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_fault,
  output logic [1:0]  mem_fault_code
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_FUNCT3   = 2'b11;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~is_store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << lo;
      2'b01:   s = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {lo, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [1:0]    lo_q, lo_d;
  logic [2:0]    f3_q, f3_d;
  logic [4:0]    rd_q, rd_d;
  logic          rw_q, rw_d;
  logic          wb_valid_q, wb_valid_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          wb_reg_write_q, wb_reg_write_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic          is_mem_s;
  logic          f3_ok_s;
  logic          misal_s;

  always_comb begin
    is_mem_s = ex_mem_read | ex_mem_write;
    f3_ok_s  = funct3_legal(ex_funct3, ex_mem_write);
    misal_s  = is_misaligned(ex_funct3, ex_alu_out[1:0]);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    lo_d           = lo_q;
    f3_d           = f3_q;
    rd_d           = rd_q;
    rw_d           = rw_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = 1'b0;
    fault_d        = 1'b0;
    code_d         = code_q;

    case (state_q)
      IDLE: begin
        if (ex_valid && !ex_flush) begin
          if (!is_mem_s) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = ex_alu_out;
            wb_rd_d        = ex_rd;
            wb_reg_write_d = ex_reg_write;
          end else if (!f3_ok_s || misal_s) begin
            // Faulting access never reaches memory; report it straight to writeback.
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            fault_d    = 1'b1;
            code_d     = f3_ok_s ? FAULT_MISALIGN : FAULT_FUNCT3;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            addr_d  = {ex_alu_out[31:2], 2'b00};
            wdata_d = ex_mem_write ? store_data(ex_funct3, ex_store_data) : 32'd0;
            wstrb_d = ex_mem_write ? store_strb(ex_funct3, ex_alu_out[1:0]) : 4'b0000;
            lo_d    = ex_alu_out[1:0];
            f3_d    = ex_funct3;
            rd_d    = ex_rd;
            rw_d    = ex_reg_write & ~ex_mem_write;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          state_d        = IDLE;
          req_d          = 1'b0;
          we_d           = 1'b0;
          wstrb_d        = 4'b0000;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_reg_write_d = rw_q;
          if (!we_q) begin
            wb_data_d = load_extract(f3_q, lo_q, dmem_rdata);
          end else begin
            wb_data_d = wb_data_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          wstrb_d    = 4'b0000;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          fault_d    = 1'b1;
          code_d     = FAULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        wstrb_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      wstrb_q        <= 4'b0000;
      lo_q           <= 2'b00;
      f3_q           <= 3'b000;
      rd_q           <= 5'd0;
      rw_q           <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= 32'd0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      fault_q        <= 1'b0;
      code_q         <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      lo_q           <= lo_d;
      f3_q           <= f3_d;
      rd_q           <= rd_d;
      rw_q           <= rw_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      fault_q        <= fault_d;
      code_q         <= code_d;
    end
  end

  assign mem_stall      = (state_q == BUSY);
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_wstrb     = wstrb_q;
  assign wb_valid       = wb_valid_q;
  assign wb_data        = wb_data_q;
  assign wb_rd          = wb_rd_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign mem_fault      = fault_q;
  assign mem_fault_code = code_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback records,
// a negedge monitor pops and compares whenever wb_valid is presented.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_flush;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        mem_stall, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_reg_write, mem_fault;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  mem_fault_code;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_flush(ex_flush),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_fault(mem_fault), .mem_fault_code(mem_fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        fault;
    logic [1:0]  code;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wb(input logic [31:0] data, input logic [4:0] rd, input logic rw,
                           input logic fault, input logic [1:0] code, input logic chk_data);
    exp_t e;
    e.data = data; e.rd = rd; e.rw = rw; e.fault = fault; e.code = code; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented writeback must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_fault && !wb_valid) check("fault_without_wb", 32'(mem_fault), 32'd0);
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb_valid", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          check("mem_fault", 32'(mem_fault), 32'(e.fault));
          if (e.fault) check("mem_fault_code", 32'(mem_fault_code), 32'(e.code));
          if (e.chk_data) begin
            check("wb_data", wb_data, e.data);
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
          end
        end
      end
    end
  end

  // Called at a negedge; presents one instruction for one cycle.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [2:0] f3, input logic flush);
    ex_valid = 1'b1; ex_alu_out = alu; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3; ex_flush = flush;
    @(negedge clk);
    ex_valid = 1'b0; ex_flush = 1'b0;
  endtask

  // Counts BUSY cycles, raising dmem_ready in BUSY cycle ready_at (0 = never).
  task automatic run_busy(input int ready_at, output int n, output int reqn);
    n = 0; reqn = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_stall) break;
      n++;
      if (dmem_req) reqn++;
      dmem_ready = (n == ready_at);
      @(negedge clk);
    end
    dmem_ready = 1'b0;
  endtask

  int n, reqn;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_alu_out = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'b000;
    ex_flush = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {mem_stall, dmem_req, dmem_we, dmem_wstrb, wb_valid, wb_reg_write,
                          mem_fault, mem_fault_code}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Non-memory pass-through
    expect_wb(32'h0000_00A5, 5'd7, 1'b1, 1'b0, 2'b00, 1'b1);
    issue(32'h0000_00A5, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    check("alu_no_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    check("alu_no_stall2", 32'(mem_stall), 32'd0);

    // Flushed instruction produces nothing
    issue(32'h1234_5678, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    check("flush_no_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);

    // LB 0x1003, ready in third BUSY cycle
    dmem_rdata = 32'h80FF_1234;
    expect_wb(32'hFFFF_FF80, 5'd5, 1'b1, 1'b0, 2'b00, 1'b1);
    issue(32'h0000_1003, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    check("lb_req", 32'(dmem_req), 32'd1);
    check("lb_we", 32'(dmem_we), 32'd0);
    check("lb_addr", dmem_addr, 32'h0000_1000);
    check("lb_wstrb", 32'(dmem_wstrb), 32'd0);
    run_busy(3, n, reqn);
    check("lb_stall_cycles", 32'(n), 32'd3);
    check("lb_req_dropped", 32'(dmem_req), 32'd0);

    // LHU then LH at 0x2002, immediate ready
    dmem_rdata = 32'hBEEF_0000;
    expect_wb(32'h0000_BEEF, 5'd9, 1'b1, 1'b0, 2'b00, 1'b1);
    issue(32'h0000_2002, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b101, 1'b0);
    check("lhu_addr", dmem_addr, 32'h0000_2000);
    run_busy(1, n, reqn);
    check("lhu_stall_cycles", 32'(n), 32'd1);
    expect_wb(32'hFFFF_BEEF, 5'd10, 1'b1, 1'b0, 2'b00, 1'b1);
    issue(32'h0000_2002, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    run_busy(1, n, reqn);

    // SB 0xC3 at 0x3001
    expect_wb(32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    issue(32'h0000_3001, 32'h0000_00C3, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    check("sb_we", 32'(dmem_we), 32'd1);
    check("sb_addr", dmem_addr, 32'h0000_3000);
    check("sb_wdata", dmem_wdata, 32'hC3C3_C3C3);
    check("sb_wstrb", 32'(dmem_wstrb), 32'b0010);
    run_busy(2, n, reqn);

    // SH upper half and SW
    expect_wb(32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    issue(32'h0000_5002, 32'h1234_ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
    check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    check("sh_wstrb", 32'(dmem_wstrb), 32'b1100);
    run_busy(1, n, reqn);
    expect_wb(32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    issue(32'h0000_5000, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0);
    check("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check("sw_wstrb", 32'(dmem_wstrb), 32'b1111);
    run_busy(1, n, reqn);

    // Misaligned LW and illegal store funct3
    expect_wb(32'd0, 5'd4, 1'b0, 1'b1, 2'b01, 1'b0);
    issue(32'h0000_4002, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
    check("misal_no_req", 32'(dmem_req), 32'd0);
    check("misal_no_stall", 32'(mem_stall), 32'd0);
    expect_wb(32'd0, 5'd0, 1'b0, 1'b1, 2'b11, 1'b0);
    issue(32'h0000_4000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
    check("illegal_no_req", 32'(dmem_req), 32'd0);
    @(negedge clk);

    // Timeout with dmem_ready held low
    expect_wb(32'd0, 5'd6, 1'b0, 1'b1, 2'b10, 1'b0);
    issue(32'h0000_6000, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
    run_busy(0, n, reqn);
    check("timeout_busy_cycles", 32'(n), 32'd16);
    check("timeout_req_cycles", 32'(reqn), 32'd16);
    check("timeout_stall_low", 32'(mem_stall), 32'd0);
    check("timeout_req_low", 32'(dmem_req), 32'd0);
    @(negedge clk);

    // Reset in BUSY cycle 5 abandons the access with no writeback
    issue(32'h0000_6000, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_req", 32'(dmem_req), 32'd0);
    check("rst_busy_stall", 32'(mem_stall), 32'd0);
    check("rst_busy_wb", 32'(wb_valid), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
